// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for one shared 32-bit ALU.
// Operands are held steady for SETTLE_CYCLES before the result is captured.
module alu_rr_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_cmd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_cmd,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp_result,
  output logic [2:0]  resp_flags,
  output logic        busy,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [2:0]  alu_command,
  input  logic [31:0] alu_result,
  input  logic        alu_carryout,
  input  logic        alu_zero,
  input  logic        alu_overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic        r_rr;
  logic        r_owner;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_cmd;
  logic [31:0] r_res;
  logic [2:0]  r_flags;
  logic        r_v0;
  logic        r_v1;

  logic w_idle;
  logic w_rdy0;
  logic w_rdy1;
  logic w_acc;
  logic w_grant;
  logic w_rsp_rdy;

  assign w_idle    = (r_state == IDLE) & ~reset;
  assign w_rdy0    = w_idle & req0_valid & (~r_rr | ~req1_valid);
  assign w_rdy1    = w_idle & req1_valid & (r_rr | ~req0_valid);
  assign w_acc     = w_rdy0 | w_rdy1;
  assign w_grant   = w_rdy1;
  assign w_rsp_rdy = r_owner ? resp1_ready : resp0_ready;

  assign req0_ready   = w_rdy0;
  assign req1_ready   = w_rdy1;
  assign resp0_valid  = r_v0;
  assign resp1_valid  = r_v1;
  assign resp_result  = r_res;
  assign resp_flags   = r_flags;
  assign busy         = (r_state != IDLE);
  assign alu_operandA = r_a;
  assign alu_operandB = r_b;
  assign alu_command  = r_cmd;

  // Next-state: accept, wait out the settle count, hold until taken.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_acc) w_next = SETTLE;
      SETTLE:  if (r_cnt == 8'd0) w_next = RESP;
      RESP:    if (w_rsp_rdy) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Operand latch on accept, settle countdown, result capture/handoff.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_rr    <= 1'b0;
      r_owner <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_cmd   <= '0;
      r_res   <= '0;
      r_flags <= '0;
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
    end else begin
      if (w_acc) begin
        r_a     <= w_grant ? req1_a : req0_a;
        r_b     <= w_grant ? req1_b : req0_b;
        r_cmd   <= w_grant ? req1_cmd : req0_cmd;
        r_owner <= w_grant;
        r_rr    <= ~w_grant;
        r_cnt   <= CNT_INIT;
      end
      if (r_state == SETTLE) begin
        if (r_cnt == 8'd0) begin
          r_res   <= alu_result;
          r_flags <= {alu_overflow, alu_zero, alu_carryout};
          r_v0    <= ~r_owner;
          r_v1    <= r_owner;
        end else begin
          r_cnt <= r_cnt - 8'd1;
        end
      end
      if ((r_state == RESP) && w_rsp_rdy) begin
        r_v0 <= 1'b0;
        r_v1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: behavioural ALU, fairness model,
// directed and randomized rounds checked with immediate assertions.
module tb_alu_rr_arbiter;

  localparam int S = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_cmd, req1_cmd;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready, resp1_ready;
  logic [31:0] resp_result;
  logic [2:0]  resp_flags;
  logic        busy;
  logic [31:0] alu_operandA, alu_operandB;
  logic [2:0]  alu_command;
  logic [31:0] alu_result;
  logic        alu_carryout, alu_zero, alu_overflow;

  int checks = 0;
  int failures = 0;
  logic fav = 1'b0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .busy(busy),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
    .alu_command(alu_command), .alu_result(alu_result),
    .alu_carryout(alu_carryout), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow)
  );

  // Returns {overflow, zero, carryout, result}.
  function automatic logic [34:0] alu_f(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [2:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic ov, z, co;
    ov = 1'b0; z = 1'b0; co = 1'b0; s = '0;
    case (c)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; co = s[32]; z = (r == 0);
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; co = s[32]; z = (r == 0);
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a ^ b;
      3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {ov, z, co, r};
  endfunction

  logic [34:0] alu_out;
  always_comb begin
    alu_out = alu_f(alu_operandA, alu_operandB, alu_command);
    alu_result   = alu_out[31:0];
    alu_carryout = alu_out[32];
    alu_zero     = alu_out[33];
    alu_overflow = alu_out[34];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_rst();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_v0", 32'(resp0_valid), 32'd0);
    chk("rst_v1", 32'(resp1_valid), 32'd0);
    chk("rst_res", resp_result, 32'd0);
    chk("rst_flg", 32'(resp_flags), 32'd0);
    chk("rst_opa", alu_operandA, 32'd0);
    chk("rst_opb", alu_operandB, 32'd0);
    chk("rst_cmd", 32'(alu_command), 32'd0);
  endtask

  // One transaction: present requests, check grant, latency, data,
  // backpressure for 'hold' cycles, then release.
  task automatic round(input logic v0, input logic v1,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [2:0] c0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input logic [2:0] c1, input int hold);
    logic g;
    logic [31:0] ea, eb;
    logic [2:0] ec;
    logic [34:0] e;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cmd = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cmd = c1;
    #1;
    if (!v0 && !v1) begin
      chk("nrq_r0", 32'(req0_ready), 32'd0);
      chk("nrq_r1", 32'(req1_ready), 32'd0);
      @(negedge clk);
      chk("nrq_busy", 32'(busy), 32'd0);
    end else begin
      g = (v0 && v1) ? fav : v1;
      chk("grant0", 32'(req0_ready), 32'(!g));
      chk("grant1", 32'(req1_ready), 32'(g));
      ea = g ? a1 : a0;
      eb = g ? b1 : b0;
      ec = g ? c1 : c0;
      e = alu_f(ea, eb, ec);
      for (int n = 1; n <= S + 1; n++) begin
        @(negedge clk);
        if (n == 1) begin
          chk("opA", alu_operandA, ea);
          chk("opB", alu_operandB, eb);
          chk("opC", 32'(alu_command), 32'(ec));
        end
        chk("busy_op", 32'(busy), 32'd1);
        chk("rdy_op", 32'({req0_ready, req1_ready}), 32'd0);
        chk("lat_own", 32'(g ? resp1_valid : resp0_valid),
            32'(n == S + 1));
        chk("lat_oth", 32'(g ? resp0_valid : resp1_valid), 32'd0);
      end
      chk("result", resp_result, e[31:0]);
      chk("flags", 32'(resp_flags), 32'(e[34:32]));
      for (int h = 0; h < hold; h++) begin
        resp0_ready = g;
        resp1_ready = !g;
        @(negedge clk);
        chk("bp_valid", 32'(g ? resp1_valid : resp0_valid), 32'd1);
        chk("bp_res", resp_result, e[31:0]);
        chk("bp_flg", 32'(resp_flags), 32'(e[34:32]));
        chk("bp_busy", 32'(busy), 32'd1);
        chk("bp_rdy", 32'({req0_ready, req1_ready}), 32'd0);
      end
      resp0_ready = !g;
      resp1_ready = g;
      @(negedge clk);
      chk("rel_v", 32'({resp0_valid, resp1_valid}), 32'd0);
      chk("rel_busy", 32'(busy), 32'd0);
      resp0_ready = 1'b0;
      resp1_ready = 1'b0;
      fav = !g;
    end
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'd1; req0_b = 32'd2; req0_cmd = 3'd0;
    req1_a = 32'd3; req1_b = 32'd4; req1_cmd = 3'd0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_r0", 32'(req0_ready), 32'd0);
      chk("rst_r1", 32'(req1_ready), 32'd0);
      chk_idle_rst();
    end
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    round(1, 0, 32'd5, 32'd7, 3'd0, 32'd0, 32'd0, 3'd0, 0);
    round(0, 1, 32'd0, 32'd0, 3'd0, 32'h8000_0000, 32'd1, 3'd1, 0);
    round(1, 0, 32'h1234, 32'h1234, 3'd1, 32'd0, 32'd0, 3'd0, 0);

    fav = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      round(1, 1, 32'(100 + i), 32'(7 * i), 3'(i),
            32'(200 + i), 32'(3 * i), 3'(i + 4), 0);
    end

    round(1, 0, 32'hFFFF_FFFF, 32'd1, 3'd0, 32'd0, 32'd0, 3'd0, 10);

    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 32'd9; req0_b = 32'd4; req0_cmd = 3'd1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    req0_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_idle_rst();
    reset = 1'b0;
    fav = 1'b0;
    for (int i = 0; i < S + 4; i++) begin
      @(negedge clk);
      chk("abt_v", 32'({resp0_valid, resp1_valid}), 32'd0);
      chk("abt_busy", 32'(busy), 32'd0);
    end
    round(0, 1, 32'd0, 32'd0, 3'd0, 32'd40, 32'd2, 3'd0, 1);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra0, rb0, ra1, rb1;
      ra0 = $urandom;
      rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
      ra1 = $urandom;
      rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
      round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ra0, rb0, 3'($urandom_range(0, 7)),
            ra1, rb1, 3'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
